rom_uart_loader: RTL and testbench

- Serial bootloader that sits directly upstream of the program ROM.
- Receives a firmware image over a UART RX line and drives the ROM write port (wen/addr/wdata) word by word.
- Holds the picoRV32 core in reset while a load is in progress and releases it when a checksum-verified image has been written.
- With no load traffic, the ROM keeps its build-time image and the core runs normally.

---
 rtl/rom_uart_loader_if.sv | 21 ++
 rtl/rom_uart_loader.sv | 231 +++++++++++++++++++++++
 tb/tb_rom_uart_loader.sv | 301 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rom_uart_loader_if.sv
// ROM write port and loader status bundle for rom_uart_loader.
// The loader drives it through the master modport; the ROM and SoC glue use the slave modport.
interface rom_uart_loader_if #(
  parameter int ADDR_W = 8
);
  logic              rom_wen;
  logic [ADDR_W-1:0] rom_addr;
  logic [31:0]       rom_wdata;
  logic              cpu_resetn;
  logic              busy;
  logic              load_ok;
  logic              load_err;

  modport master (
    output rom_wen, rom_addr, rom_wdata, cpu_resetn, busy, load_ok, load_err
  );

  modport slave (
    input rom_wen, rom_addr, rom_wdata, cpu_resetn, busy, load_ok, load_err
  );
endinterface

// File: rtl/rom_uart_loader.sv
// UART (8N1) bootloader: A5 | LEN_LO | LEN_HI | 4*LEN data bytes | CHK, written word by word into the ROM.
// Optional macro LOADER_TIMEOUT_EN aborts a frame after TIMEOUT idle cycles between bytes.
module rom_uart_loader #(
  parameter int CLK_DIV = 104,
  parameter int ADDR_W  = 8,
  parameter int TIMEOUT = 1000000
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               rx,
  rom_uart_loader_if.master  bus
);
  localparam int         DEPTH     = 1 << ADDR_W;
  localparam int         CNT_W     = $clog2(CLK_DIV);
  localparam logic [7:0] SYNC_BYTE = 8'hA5;

  if (CLK_DIV < 4 || TIMEOUT < 1) begin : g_bad_param
    $error("rom_uart_loader: CLK_DIV must be >= 4 and TIMEOUT >= 1");
  end

  typedef enum logic [2:0] {
    S_IDLE, S_LEN0, S_LEN1, S_DATA, S_CHK, S_DONE, S_ERR
  } state_t;

  // ---------------- UART receiver ----------------
  logic             rx_meta, rx_sync, rx_prev;
  logic             rx_active;
  logic [CNT_W-1:0] baud_cnt;
  logic [3:0]       bit_idx;     // 0 = start, 1..8 = data, 9 = stop
  logic [7:0]       rx_shift;
  logic             rx_strobe;
  logic             frame_err;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      // NOTE: the synchroniser resets to the idle-high level so reset release is not seen as a start edge.
      rx_meta   <= 1'b1;
      rx_sync   <= 1'b1;
      rx_prev   <= 1'b1;
      rx_active <= 1'b0;
      baud_cnt  <= '0;
      bit_idx   <= '0;
      rx_shift  <= '0;
      rx_strobe <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop here samples pre-edge values of the others.
      rx_meta   <= rx;
      rx_sync   <= rx_meta;
      rx_prev   <= rx_sync;
      rx_strobe <= 1'b0;
      frame_err <= 1'b0;
      if (!rx_active) begin
        if (rx_prev && !rx_sync) begin
          rx_active <= 1'b1;
          baud_cnt  <= CNT_W'(CLK_DIV / 2 - 1);
          bit_idx   <= 4'd0;
        end
      end else if (baud_cnt != '0) begin
        baud_cnt <= baud_cnt - 1'b1;
      end else begin
        baud_cnt <= CNT_W'(CLK_DIV - 1);
        if (bit_idx == 4'd0) begin
          if (rx_sync) rx_active <= 1'b0;   // glitch, not a real start bit
          else         bit_idx   <= 4'd1;
        end else if (bit_idx != 4'd9) begin
          rx_shift <= {rx_sync, rx_shift[7:1]};
          bit_idx  <= bit_idx + 4'd1;
        end else begin
          rx_active <= 1'b0;
          rx_strobe <= rx_sync;
          frame_err <= !rx_sync;
        end
      end
    end
  end

  // ---------------- Frame FSM ----------------
  state_t            state, state_n;
  logic [15:0]       len_q, len_n;
  logic [ADDR_W-1:0] index, index_n;
  logic [31:0]       word_q, word_n;
  logic [1:0]        byte_cnt, byte_cnt_n;
  logic [7:0]        chk, chk_n;
  logic              wen_q, wen_n;
  logic [ADDR_W-1:0] addr_q, addr_n;
  logic [31:0]       wdata_q, wdata_n;
  logic              cpu_q, cpu_n;
  logic              busy_q, busy_n;
  logic              ok_q, ok_n;
  logic              err_q, err_n;
  logic [15:0]       len_new;
  logic [7:0]        chk_add;
`ifdef LOADER_TIMEOUT_EN
  logic [31:0]       tmo_cnt, tmo_n;
`endif

  assign len_new = {rx_shift, len_q[7:0]};
  assign chk_add = chk + rx_shift;

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    state_n    = state;
    len_n      = len_q;
    index_n    = index;
    word_n     = word_q;
    byte_cnt_n = byte_cnt;
    chk_n      = chk;
    wen_n      = 1'b0;
    addr_n     = addr_q;
    wdata_n    = wdata_q;
    cpu_n      = cpu_q;
    busy_n     = busy_q;
    ok_n       = ok_q;
    err_n      = err_q;
`ifdef LOADER_TIMEOUT_EN
    tmo_n      = '0;
`endif
    case (state)
      S_IDLE: begin
        // A failed image keeps the core parked until a later load succeeds.
        if (!err_q) cpu_n = 1'b1;
        if (rx_strobe && rx_shift == SYNC_BYTE) begin
          cpu_n   = 1'b0;
          busy_n  = 1'b1;
          ok_n    = 1'b0;
          err_n   = 1'b0;
          state_n = S_LEN0;
        end
      end
      S_LEN0: if (rx_strobe) begin
        len_n[7:0] = rx_shift;
        state_n    = S_LEN1;
      end
      S_LEN1: if (rx_strobe) begin
        len_n = len_new;
        if (len_new == 16'd0 || 32'(len_new) > DEPTH) begin
          state_n = S_ERR;
        end else begin
          index_n    = '0;
          chk_n      = '0;
          byte_cnt_n = '0;
          state_n    = S_DATA;
        end
      end
      S_DATA: if (rx_strobe) begin
        word_n     = {rx_shift, word_q[31:8]};
        chk_n      = chk_add;
        byte_cnt_n = byte_cnt + 2'd1;
        if (byte_cnt == 2'd3) begin
          wen_n   = 1'b1;
          addr_n  = index;
          wdata_n = word_n;
          index_n = index + 1'b1;
          if (16'(index) == len_q - 16'd1) state_n = S_CHK;
        end
      end
      S_CHK: if (rx_strobe) begin
        state_n = (chk_add == 8'd0) ? S_DONE : S_ERR;
      end
      S_DONE: begin
        ok_n    = 1'b1;
        busy_n  = 1'b0;
        state_n = S_IDLE;
      end
      S_ERR: begin
        err_n   = 1'b1;
        busy_n  = 1'b0;
        cpu_n   = 1'b0;
        state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase

    if (state inside {S_LEN0, S_LEN1, S_DATA, S_CHK}) begin
      if (frame_err) state_n = S_ERR;
`ifdef LOADER_TIMEOUT_EN
      if (!rx_strobe) begin
        tmo_n = tmo_cnt + 32'd1;
        if (tmo_cnt == 32'(TIMEOUT - 1)) state_n = S_ERR;
      end
`endif
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state    <= S_IDLE;
      len_q    <= '0;
      index    <= '0;
      word_q   <= '0;
      byte_cnt <= '0;
      chk      <= '0;
      wen_q    <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      cpu_q    <= 1'b0;
      busy_q   <= 1'b0;
      ok_q     <= 1'b0;
      err_q    <= 1'b0;
`ifdef LOADER_TIMEOUT_EN
      tmo_cnt  <= '0;
`endif
    end else begin
      state    <= state_n;
      len_q    <= len_n;
      index    <= index_n;
      word_q   <= word_n;
      byte_cnt <= byte_cnt_n;
      chk      <= chk_n;
      wen_q    <= wen_n;
      addr_q   <= addr_n;
      wdata_q  <= wdata_n;
      cpu_q    <= cpu_n;
      busy_q   <= busy_n;
      ok_q     <= ok_n;
      err_q    <= err_n;
`ifdef LOADER_TIMEOUT_EN
      tmo_cnt  <= tmo_n;
`endif
    end
  end

  assign bus.rom_wen    = wen_q;
  assign bus.rom_addr   = addr_q;
  assign bus.rom_wdata  = wdata_q;
  assign bus.cpu_resetn = cpu_q;
  assign bus.busy       = busy_q;
  assign bus.load_ok    = ok_q;
  assign bus.load_err   = err_q;
endmodule

// File: tb/tb_rom_uart_loader.sv
// Self-checking bench for rom_uart_loader: directed frames plus randomized frames against a byte-level model.
// Define LOADER_TIMEOUT_EN to also exercise the inter-byte timeout (TIMEOUT=100).
module tb_rom_uart_loader;
  localparam int CLK_DIV = 4;
  localparam int ADDR_W  = 8;
`ifdef LOADER_TIMEOUT_EN
  localparam int TIMEOUT = 100;
`else
  localparam int TIMEOUT = 1000000;
`endif

  typedef logic [7:0] byte_t;
  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [31:0]       data;
  } wr_t;

  logic clk    = 1'b0;
  logic resetn = 1'b1;
  logic rx     = 1'b1;

  rom_uart_loader_if #(.ADDR_W(ADDR_W)) bus ();

  rom_uart_loader #(.CLK_DIV(CLK_DIV), .ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
    .clk   (clk),
    .resetn(resetn),
    .rx    (rx),
    .bus   (bus.master)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  wr_t got_q[$];
  wr_t exp_q[$];
  int cyc = 0, fall_cyc = -1, rise_cyc = -1;
  int long_wen = 0, early_release = 0, busy_rise = 0;
  logic prev_wen = 1'b0, prev_busy = 1'b0, prev_cpu = 1'b0;

  // Passive monitor: records ROM writes and output event timing.
  always @(negedge clk) begin
    cyc++;
    if (bus.rom_wen === 1'b1) got_q.push_back(wr_t'{bus.rom_addr, bus.rom_wdata});
    if (bus.rom_wen === 1'b1 && prev_wen) long_wen++;
    if (bus.busy === 1'b1 && bus.cpu_resetn === 1'b1) early_release++;
    if (prev_busy && bus.busy === 1'b0) fall_cyc = cyc;
    if (!prev_busy && bus.busy === 1'b1) busy_rise++;
    if (!prev_cpu && bus.cpu_resetn === 1'b1) rise_cyc = cyc;
    prev_wen  = (bus.rom_wen === 1'b1);
    prev_busy = (bus.busy === 1'b1);
    prev_cpu  = (bus.cpu_resetn === 1'b1);
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // ---------------- stimulus and model ----------------
  task automatic send_byte(input byte_t b, input logic stop_bit);
    @(negedge clk) rx = 1'b0;
    repeat (CLK_DIV) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (CLK_DIV) @(negedge clk);
    end
    rx = stop_bit;
    repeat (CLK_DIV) @(negedge clk);
    rx = 1'b1;
    repeat (2 * CLK_DIV) @(negedge clk);
  endtask

  task automatic send_frame(input byte_t q[$], input int bad_idx);
    foreach (q[i]) send_byte(q[i], (i == bad_idx) ? 1'b0 : 1'b1);
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (bus.busy === 1'b1 && n < 400) begin
      @(negedge clk);
      n++;
    end
    repeat (3) @(negedge clk);
    vectors++; if (bus.busy !== 1'b0) begin miscompares++; $display("FAIL %s_idle: busy=%b after %0d cycles, want 0", tag, bus.busy, n); end
  endtask

  function automatic void rand_bytes(input int n, output byte_t q[$]);
    q.delete();
    for (int i = 0; i < n; i++) q.push_back(byte_t'($urandom_range(0, 255)));
  endfunction

  // Frame bytes: sync, length, payload, then CHK chosen so the payload+CHK sum is 0 mod 256 (plus delta).
  function automatic void build_frame(input logic [15:0] len, input byte_t d[$], input byte_t delta,
                                      output byte_t q[$]);
    int s = 0;
    foreach (d[i]) s += int'(d[i]);
    q = '{8'hA5, len[7:0], len[15:8]};
    foreach (d[i]) q.push_back(d[i]);
    q.push_back(byte_t'((256 - s % 256) % 256 + int'(delta)));
  endfunction

  // Expected ROM writes: word w at address w, little-endian from the payload bytes.
  function automatic void expect_words(input byte_t d[$], input int nwords);
    exp_q.delete();
    for (int w = 0; w < nwords; w++)
      exp_q.push_back(wr_t'{ADDR_W'(w), {d[4*w+3], d[4*w+2], d[4*w+1], d[4*w]}});
  endfunction

  function automatic void clear_mon();
    got_q.delete();
    fall_cyc = -1;
    rise_cyc = -1;
  endfunction

  // ---------------- tests ----------------
  task automatic test_reset();
    resetn = 1'b1;
    #2 resetn = 1'b0;
    #1;
    vectors++; if ({bus.rom_wen, bus.rom_addr, bus.rom_wdata, bus.cpu_resetn, bus.busy, bus.load_ok, bus.load_err} !== '0) begin
      miscompares++; $display("FAIL reset_vals: wen=%b addr=%h wdata=%h cpu=%b busy=%b ok=%b err=%b, want all 0",
        bus.rom_wen, bus.rom_addr, bus.rom_wdata, bus.cpu_resetn, bus.busy, bus.load_ok, bus.load_err); end
    repeat (3) @(negedge clk);
    clear_mon();
    resetn = 1'b1;
    #1;
    vectors++; if (bus.cpu_resetn !== 1'b0) begin miscompares++; $display("FAIL reset_cpu_hold: cpu_resetn=%b, want 0", bus.cpu_resetn); end
    @(negedge clk);
    vectors++; if (bus.cpu_resetn !== 1'b1) begin miscompares++; $display("FAIL reset_cpu_rel: cpu_resetn=%b, want 1", bus.cpu_resetn); end
    repeat (20) @(negedge clk);
    vectors++; if (bus.busy !== 1'b0 || got_q.size() != 0) begin miscompares++; $display("FAIL reset_quiet: busy=%b writes=%0d, want 0/0", bus.busy, got_q.size()); end
  endtask

  task automatic test_good_frame();
    byte_t d[$] = '{8'hDD, 8'hCC, 8'hBB, 8'hAA, 8'h44, 8'h33, 8'h22, 8'h11};
    byte_t q[$] = '{8'hA5, 8'h02, 8'h00, 8'hDD, 8'hCC, 8'hBB, 8'hAA, 8'h44, 8'h33, 8'h22, 8'h11, 8'h48};
    clear_mon();
    expect_words(d, 2);
    send_frame(q, -1);
    wait_idle("good");
    vectors++; if (got_q.size() != exp_q.size()) begin miscompares++; $display("FAIL good_nwr: got %0d writes, want %0d", got_q.size(), exp_q.size()); end
    else foreach (exp_q[i]) begin vectors++; if (got_q[i] !== exp_q[i]) begin miscompares++; $display("FAIL good_wr%0d: got %h, want %h", i, got_q[i], exp_q[i]); end end
    vectors++; if ({bus.load_ok, bus.load_err, bus.cpu_resetn} !== 3'b101) begin miscompares++; $display("FAIL good_flags: ok/err/cpu=%b, want 101", {bus.load_ok, bus.load_err, bus.cpu_resetn}); end
    vectors++; if (rise_cyc - fall_cyc != 1) begin miscompares++; $display("FAIL good_release: cpu rise-busy fall=%0d cycles, want 1", rise_cyc - fall_cyc); end
  endtask

  task automatic test_bad_chk();
    byte_t d[$] = '{8'hDD, 8'hCC, 8'hBB, 8'hAA, 8'h44, 8'h33, 8'h22, 8'h11};
    byte_t q[$];
    clear_mon();
    build_frame(16'd2, d, 8'd1, q);
    expect_words(d, 2);
    send_frame(q, -1);
    wait_idle("badchk");
    repeat (10) @(negedge clk);
    vectors++; if (got_q.size() != exp_q.size()) begin miscompares++; $display("FAIL badchk_nwr: got %0d writes, want %0d", got_q.size(), exp_q.size()); end
    else foreach (exp_q[i]) begin vectors++; if (got_q[i] !== exp_q[i]) begin miscompares++; $display("FAIL badchk_wr%0d: got %h, want %h", i, got_q[i], exp_q[i]); end end
    vectors++; if ({bus.load_ok, bus.load_err, bus.cpu_resetn} !== 3'b010) begin miscompares++; $display("FAIL badchk_flags: ok/err/cpu=%b, want 010", {bus.load_ok, bus.load_err, bus.cpu_resetn}); end
    clear_mon();
    build_frame(16'd2, d, 8'd0, q);
    send_frame(q, -1);
    wait_idle("recover");
    vectors++; if (got_q.size() != exp_q.size()) begin miscompares++; $display("FAIL recover_nwr: got %0d writes, want %0d", got_q.size(), exp_q.size()); end
    vectors++; if ({bus.load_ok, bus.load_err, bus.cpu_resetn} !== 3'b101) begin miscompares++; $display("FAIL recover_flags: ok/err/cpu=%b, want 101", {bus.load_ok, bus.load_err, bus.cpu_resetn}); end
  endtask

  task automatic test_bad_len();
    byte_t q0[$]   = '{8'hA5, 8'h00, 8'h00};
    byte_t q257[$] = '{8'hA5, 8'h01, 8'h01};
    byte_t d[$];
    byte_t q[$];
    clear_mon();
    send_frame(q0, -1);
    wait_idle("len0");
    vectors++; if (got_q.size() != 0 || {bus.load_ok, bus.load_err, bus.cpu_resetn} !== 3'b010) begin miscompares++;
      $display("FAIL len0: writes=%0d ok/err/cpu=%b, want 0 and 010", got_q.size(), {bus.load_ok, bus.load_err, bus.cpu_resetn}); end
    rand_bytes(4, d);
    build_frame(16'd1, d, 8'd0, q);
    send_frame(q, -1);
    wait_idle("len1");
    vectors++; if (bus.load_err !== 1'b0) begin miscompares++; $display("FAIL len1_err: load_err=%b, want 0", bus.load_err); end
    clear_mon();
    send_frame(q257, -1);
    wait_idle("len257");
    vectors++; if (got_q.size() != 0 || {bus.load_ok, bus.load_err, bus.cpu_resetn} !== 3'b010) begin miscompares++;
      $display("FAIL len257: writes=%0d ok/err/cpu=%b, want 0 and 010", got_q.size(), {bus.load_ok, bus.load_err, bus.cpu_resetn}); end
  endtask

  task automatic test_framing();
    byte_t d[$];
    byte_t q[$];
    rand_bytes(4, d);
    build_frame(16'd1, d, 8'd0, q);
    send_frame(q, -1);
    wait_idle("pre_garbage");
    clear_mon();
    busy_rise = 0;
    send_byte(8'h00, 1'b1);
    send_byte(8'hFF, 1'b1);
    send_byte(8'hA5, 1'b0);
    repeat (10) @(negedge clk);
    vectors++; if (busy_rise != 0 || got_q.size() != 0 || {bus.load_ok, bus.cpu_resetn} !== 2'b11) begin miscompares++;
      $display("FAIL garbage: busy_rise=%0d writes=%0d ok/cpu=%b, want 0 0 11", busy_rise, got_q.size(), {bus.load_ok, bus.cpu_resetn}); end
    d = '{8'hDD, 8'hCC, 8'hBB, 8'hAA, 8'h44, 8'h33, 8'h22, 8'h11};
    build_frame(16'd2, d, 8'd0, q);
    clear_mon();
    send_frame(q, 4);
    wait_idle("framing");
    vectors++; if (got_q.size() != 0 || {bus.load_ok, bus.load_err, bus.cpu_resetn} !== 3'b010) begin miscompares++;
      $display("FAIL framing: writes=%0d ok/err/cpu=%b, want 0 and 010", got_q.size(), {bus.load_ok, bus.load_err, bus.cpu_resetn}); end
  endtask

  task automatic test_reset_mid();
    byte_t d[$];
    byte_t q[$];
    rand_bytes(8, d);
    build_frame(16'd2, d, 8'd0, q);
    expect_words(d, 1);
    clear_mon();
    for (int i = 0; i < 8; i++) send_byte(q[i], 1'b1);
    vectors++; if (got_q.size() != 1 || (got_q.size() == 1 && got_q[0] !== exp_q[0])) begin miscompares++;
      $display("FAIL mid_partial: writes=%0d first=%h, want 1 write %h", got_q.size(), (got_q.size() > 0) ? got_q[0] : '0, exp_q[0]); end
    vectors++; if (bus.busy !== 1'b1) begin miscompares++; $display("FAIL mid_busy: busy=%b, want 1", bus.busy); end
    #2 resetn = 1'b0;
    #1;
    vectors++; if ({bus.rom_wen, bus.rom_addr, bus.rom_wdata, bus.cpu_resetn, bus.busy, bus.load_ok, bus.load_err} !== '0) begin
      miscompares++; $display("FAIL mid_reset_vals: addr=%h wdata=%h cpu=%b busy=%b, want all 0", bus.rom_addr, bus.rom_wdata, bus.cpu_resetn, bus.busy); end
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    vectors++; if (bus.cpu_resetn !== 1'b1) begin miscompares++; $display("FAIL mid_rerelease: cpu_resetn=%b, want 1", bus.cpu_resetn); end
    rand_bytes(8, d);
    build_frame(16'd2, d, 8'd0, q);
    expect_words(d, 2);
    clear_mon();
    send_frame(q, -1);
    wait_idle("mid_reload");
    vectors++; if (got_q.size() != exp_q.size()) begin miscompares++; $display("FAIL mid_nwr: got %0d writes, want %0d", got_q.size(), exp_q.size()); end
    else foreach (exp_q[i]) begin vectors++; if (got_q[i] !== exp_q[i]) begin miscompares++; $display("FAIL mid_wr%0d: got %h, want %h", i, got_q[i], exp_q[i]); end end
    vectors++; if ({bus.load_ok, bus.load_err, bus.cpu_resetn} !== 3'b101) begin miscompares++; $display("FAIL mid_flags: ok/err/cpu=%b, want 101", {bus.load_ok, bus.load_err, bus.cpu_resetn}); end
  endtask

  task automatic test_random_frames();
    byte_t d[$];
    byte_t q[$];
    byte_t delta;
    byte_t g;
    int    len;
    logic  good;
    for (int t = 0; t < 6; t++) begin
      for (int k = 0; k < int'($urandom_range(0, 2)); k++) begin
        g = byte_t'($urandom_range(0, 255));
        send_byte((g == 8'hA5) ? 8'h5A : g, 1'b1);
      end
      len   = int'($urandom_range(1, 3));
      good  = ($urandom_range(0, 1) == 1);
      delta = good ? 8'd0 : byte_t'($urandom_range(1, 255));
      rand_bytes(4 * len, d);
      build_frame(16'(len), d, delta, q);
      expect_words(d, len);
      clear_mon();
      send_frame(q, -1);
      wait_idle("rand");
      vectors++; if (got_q.size() != exp_q.size()) begin miscompares++; $display("FAIL rand%0d_nwr: got %0d writes, want %0d", t, got_q.size(), exp_q.size()); end
      else foreach (exp_q[i]) begin vectors++; if (got_q[i] !== exp_q[i]) begin miscompares++; $display("FAIL rand%0d_wr%0d: got %h, want %h", t, i, got_q[i], exp_q[i]); end end
      vectors++; if ({bus.load_ok, bus.load_err, bus.cpu_resetn} !== {good, !good, good}) begin miscompares++;
        $display("FAIL rand%0d_flags: ok/err/cpu=%b, want %b", t, {bus.load_ok, bus.load_err, bus.cpu_resetn}, {good, !good, good}); end
    end
  endtask

`ifdef LOADER_TIMEOUT_EN
  task automatic test_timeout();
    byte_t q[$] = '{8'hA5, 8'h02, 8'h00};
    clear_mon();
    send_frame(q, -1);
    repeat (101) @(negedge clk);
    wait_idle("timeout");
    vectors++; if (got_q.size() != 0 || {bus.load_ok, bus.load_err, bus.cpu_resetn} !== 3'b010) begin miscompares++;
      $display("FAIL timeout: writes=%0d ok/err/cpu=%b, want 0 and 010", got_q.size(), {bus.load_ok, bus.load_err, bus.cpu_resetn}); end
  endtask
`endif

  initial begin
    test_reset();
    test_good_frame();
    test_bad_chk();
    test_bad_len();
    test_framing();
    test_reset_mid();
    test_random_frames();
`ifdef LOADER_TIMEOUT_EN
    test_timeout();
`endif
    vectors++; if (long_wen != 0) begin miscompares++; $display("FAIL wen_width: %0d multi-cycle write strobes, want 0", long_wen); end
    vectors++; if (early_release != 0) begin miscompares++; $display("FAIL cpu_during_busy: %0d cycles with core released while busy, want 0", early_release); end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
